// File: rtl/demux_stream_1to2_if.sv
// demux_stream_1to2_if: input and two output valid/ready streams of the 1-to-2 demultiplexer
interface demux_stream_1to2_if #(parameter int Width = 32) ();
  logic [Width-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [Width-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
  );
  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
  );
endinterface

// File: rtl/demux_stream_1to2.sv
// demux_stream_1to2: registered 1-to-2 stream demux with a 2-entry FIFO per channel; beat counters built only with DEMUX_STREAM_CNT_EN
module demux_stream_1to2 #(
  parameter int Width    = 32,
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  demux_stream_1to2_if.slave  bus,
  output logic [CntWidth-1:0] cnt0,
  output logic [CntWidth-1:0] cnt1
);
  logic [Width-1:0] q [2][2];
  logic [1:0]       occ [2];
  logic [1:0]       rem [2];
  logic [1:0]       rdy, vld, pop, push;
  logic             acc;
  assign bus.in_ready = (bus.in_sel ? occ[1] : occ[0]) != 2'd2;
  assign acc  = bus.in_valid && bus.in_ready;
  assign rdy  = {bus.out1_ready, bus.out0_ready};
  assign push = {acc && bus.in_sel, acc && !bus.in_sel};
  always_comb begin
    vld = '0;
    pop = '0;
    rem[0] = '0;
    rem[1] = '0;
    for (int c = 0; c < 2; c++) begin
      vld[c] = occ[c] != 2'd0;
      pop[c] = vld[c] && rdy[c];
      rem[c] = occ[c] - 2'(pop[c]);
    end
  end
  // slot 0 is the head; a push lands at the first slot left free after this cycle's pop
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        occ[c]  <= '0;
        q[c][0] <= '0;
        q[c][1] <= '0;
      end else begin
        if (pop[c]) q[c][0] <= q[c][1];
        if (push[c]) q[c][rem[c][0]] <= bus.in_data;
        occ[c] <= rem[c] + 2'(push[c]);
      end
    end
  end
  assign bus.out0_valid = vld[0];
  assign bus.out1_valid = vld[1];
  assign bus.out0_data  = vld[0] ? q[0][0] : '0;
  assign bus.out1_data  = vld[1] ? q[1][0] : '0;
`ifdef DEMUX_STREAM_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push[0]) cnt0 <= cnt0 + CntWidth'(1);
      if (push[1]) cnt1 <= cnt1 + CntWidth'(1);
    end
  end
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif
endmodule

// File: tb/tb_demux_stream_1to2.sv
// tb_demux_stream_1to2: directed and random stimulus checked against a queue-based reference model
module tb_demux_stream_1to2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt0, cnt1;
  logic [3:0] ecnt0, ecnt1;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int n_chk = 0;
  int n_pass = 0;
  demux_stream_1to2_if #(.Width(32)) bus ();
  demux_stream_1to2 #(.Width(32), .CntWidth(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cnt0(cnt0), .cnt1(cnt1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [3:0] exp_cnt(input logic [3:0] v);
`ifdef DEMUX_STREAM_CNT_EN
    return v;
`else
    return 4'd0 & v;
`endif
  endfunction
  // drive one cycle, check every output against the model, then advance the model at the edge
  task automatic cycle(input logic r, input logic v, input logic s, input logic [31:0] d,
                       input logic r0, input logic r1, output logic accepted);
    logic exp_rdy;
    @(negedge clk);
    rst = r;
    bus.in_valid = v;
    bus.in_sel = s;
    bus.in_data = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    #1;
    exp_rdy = (s ? q1.size() : q0.size()) != 2;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
    chk("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
    chk("out0_data", bus.out0_data, q0.size() != 0 ? q0[0] : 32'd0);
    chk("out1_data", bus.out1_data, q1.size() != 0 ? q1[0] : 32'd0);
    chk("cnt0", 32'(cnt0), 32'(exp_cnt(ecnt0)));
    chk("cnt1", 32'(cnt1), 32'(exp_cnt(ecnt1)));
    accepted = !r && v && exp_rdy;
    @(posedge clk);
    if (r) begin
      q0.delete();
      q1.delete();
      ecnt0 = 4'd0;
      ecnt1 = 4'd0;
    end else begin
      if (q0.size() != 0 && r0) void'(q0.pop_front());
      if (q1.size() != 0 && r1) void'(q1.pop_front());
      if (accepted && !s) begin q0.push_back(d); ecnt0 = ecnt0 + 4'd1; end
      if (accepted && s)  begin q1.push_back(d); ecnt1 = ecnt1 + 4'd1; end
    end
  endtask
  initial begin
    logic a;
    logic v, s, hold;
    logic [31:0] d;
    ecnt0 = 4'd0;
    ecnt1 = 4'd0;
    bus.in_valid = 1'b1;
    bus.in_sel = 1'b0;
    bus.in_data = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    @(posedge clk);
    cycle(1, 1, 0, 32'hDEAD0001, 0, 0, a);
    cycle(1, 1, 1, 32'hDEAD0002, 0, 0, a);
    cycle(0, 0, 0, 32'h0, 0, 0, a);
    cycle(0, 1, 0, 32'hA5A5A5A5, 0, 0, a);
    cycle(0, 0, 0, 32'h0, 0, 0, a);
    cycle(1, 0, 0, 32'h0, 0, 0, a);
    cycle(0, 1, 1, 32'h11, 0, 0, a);
    cycle(0, 1, 1, 32'h22, 0, 0, a);
    cycle(0, 1, 1, 32'h33, 0, 0, a);
    chk("bp_stall", 32'(a), 32'd0);
    cycle(0, 1, 0, 32'h33, 0, 0, a);
    chk("bp_other", 32'(a), 32'd1);
    cycle(0, 1, 1, 32'h44, 0, 1, a);
    chk("full_pop_stall", 32'(a), 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 1, 1, a);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 32'(i), 1, 0, a);
      chk("stream_acc", 32'(a), 32'd1);
    end
    cycle(0, 0, 0, 32'h0, 1, 0, a);
    cycle(0, 1, 0, 32'hB0, 0, 0, a);
    cycle(0, 1, 0, 32'hB1, 0, 0, a);
    cycle(0, 1, 1, 32'hC0, 0, 0, a);
    cycle(1, 0, 0, 32'h0, 0, 0, a);
    cycle(0, 0, 0, 32'h0, 1, 1, a);
    cycle(0, 0, 0, 32'h0, 1, 1, a);
    for (int i = 0; i < 17; i++) cycle(0, 1, 1, 32'(100 + i), 0, 1, a);
    cycle(0, 0, 0, 32'h0, 0, 1, a);
    chk("wrap_cnt1", 32'(cnt1), 32'(exp_cnt(4'd1)));
    chk("wrap_cnt0", 32'(cnt0), 32'd0);
    hold = 1'b0;
    v = 1'b0;
    s = 1'b0;
    d = '0;
    for (int i = 0; i < 2000; i++) begin
      logic r;
      r = ($urandom_range(63) == 0);
      if (!hold) begin
        v = $urandom_range(3) != 0;
        s = $urandom_range(1) == 1;
        d = $urandom;
      end
      cycle(r, v, s, d, $urandom_range(9) < 6, $urandom_range(9) < 4, a);
      hold = v && !a && !r;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/demux_stream_1to2.md
# demux_stream_1to2

Registered 1-to-2 stream demultiplexer: the inverse of the datapath 2:1 select mux. It accepts one word per cycle on a valid/ready input and routes it to output channel 0 or 1 according to a per-beat select bit. Each output channel buffers words in a private 2-entry FIFO, so back-pressure on one channel does not block traffic to the other. It sits between a producer stage and two consumer stages, for example splitting writeback traffic between the register file and the memory-mapped I/O path.

## Interface
Parameters:
- Width, 32, data word width in bits
- CntWidth, 16, width of the per-channel beat counters

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  Width  input word
- in_sel  input  1  destination: 0 routes to channel 0, 1 routes to channel 1
- in_valid  input  1  input word and select are valid
- in_ready  output  1  the selected channel can accept a word this cycle
- out0_data  output  Width  head word of channel 0
- out0_valid  output  1  channel 0 FIFO is non-empty
- out0_ready  input  1  channel 0 consumer takes the head word
- out1_data, out1_valid, out1_ready  same as above, for channel 1
- cnt0  output  CntWidth  number of beats accepted for channel 0
- cnt1  output  CntWidth  number of beats accepted for channel 1

## Operation
- Each channel c has a 2-entry FIFO with occupancy occ_c in {0,1,2}.
- in_ready = (in_sel ? occ_1 : occ_0) != 2.
  - in_ready is combinational on in_sel.
  - It does not depend on out*_ready; there is no ready pass-through.
- Accept: in_valid && in_ready. The word is pushed into the FIFO of the selected channel only.
- Producer rule: while in_valid is high and in_ready is low, in_data and in_sel are held stable.
- Pop on channel c: outc_valid && outc_ready. The head word is removed.
- Push and pop on the same channel in the same cycle:
  - occupancy is unchanged;
  - order is preserved, so the pushed word goes behind the remaining entry.
- outc_valid = (occ_c != 0). outc_data = head entry when valid, otherwise 0.
- Order is FIFO within each channel. There is no ordering relation between the two channels.
- outc_ready asserted while the channel is empty has no effect.
- Counters: cnt_c increments by 1 on every accepted beat routed to channel c. It wraps from 2^CntWidth-1 to 0.

## Timing
- Reset (rst=1 at a clock edge) clears all state:
  - occ_0 = occ_1 = 0
  - out0_valid = out1_valid = 0
  - out0_data = out1_data = 0
  - cnt0 = cnt1 = 0
  - FIFO contents are discarded.
- Reset during operation discards in-flight words and takes priority over any push or pop in that cycle.
- While rst=1, in_ready still follows the cleared occupancy, i.e. it is 1, but no accept takes effect.
- Latency: a word accepted at edge N is visible on outc_data with outc_valid=1 in the cycle after edge N.
- Throughput: one word per cycle per channel is sustained when the consumer holds outc_ready=1.
- Full-channel stall:
  - With occ_c=2, in_ready=0 whenever in_sel=c, even if outc_ready=1 in that cycle.
  - in_ready rises the cycle after the pop.
- The counters update at the same edge as the accepting push.

## Configuration
- DEMUX_STREAM_CNT_EN defined: cnt0 and cnt1 operate as described above.
- DEMUX_STREAM_CNT_EN undefined:
  - the counter registers are not built;
  - cnt0 and cnt1 are tied to 0;
  - all other behaviour is identical.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 -> out0_valid=out1_valid=0, cnt0=cnt1=0, and no word appears after reset drops.
- Single route:
  - Stimulus: in_data=0xA5A5A5A5, in_sel=0, in_valid=1 for one cycle, with out0_ready=0.
  - Response: next cycle out0_valid=1, out0_data=0xA5A5A5A5, out1_valid=0, cnt0=1.
- Back-pressure isolation:
  - Stimulus: push 0x11 then 0x22 to channel 1 with out1_ready=0.
  - Response: with in_sel=1, in_ready=0; with in_sel=0, in_ready=1 and 0x33 reaches out0.
  - Then raise out1_ready: out1 delivers 0x11 then 0x22 in order.
- Streaming:
  - Stimulus: out0_ready=1 and 8 consecutive beats 0..7 to channel 0.
  - Response: in_ready stays 1 throughout; out0 shows 0..7 on 8 consecutive cycles, one cycle after each accept.
- Mid-operation reset: with occ_0=2 and occ_1=1, pulse rst for one cycle -> both valids are 0 the next cycle and the old words never reappear.
- Counter wrap (CntWidth=4, macro defined): 17 beats to channel 1 -> cnt1=1, cnt0=0. With the macro undefined, cnt1=0 throughout.
